duty_scaler: RTL and testbench

Sequenced front end for the signed pipelined multiplier in the duty path. On a start strobe it walks a per-transducer duty BRAM, multiplies each duty word by the current modulation value through an internal instance of the shared `mult` block (latency 3), and emits one scaled duty word per cycle with index and valid. It sits between the duty/phase BRAM and the PWM timing stage.

---
 rtl/duty_scaler.sv | 190 +++++++++++++++++++
 tb/tb_duty_scaler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/duty_scaler.sv
// Sequenced duty-word scaler: walks the duty BRAM on START and scales each word by (MOD+1)/2^MOD_WIDTH.
// Build option: define DUTY_SCALER_ROUND_EN to round half up before the output slice instead of truncating.

module mult #(
  parameter int A_W = 14,
  parameter int B_W = 10
) (
  input  logic                     i_clk,
  input  logic signed [A_W-1:0]    i_a,
  input  logic signed [B_W-1:0]    i_b,
  output logic signed [A_W+B_W-1:0] o_p
);
  localparam int P_W = A_W + B_W;

  logic signed [A_W-1:0] r_a;
  logic signed [B_W-1:0] r_b;
  logic signed [P_W-1:0] r_p;
  logic signed [P_W-1:0] r_out;

  // Three-stage pipeline; no reset, stale contents are masked by the caller's valid pipeline.
  always_ff @(posedge i_clk) begin
    r_a   <= i_a;
    r_b   <= i_b;
    r_p   <= P_W'(r_a) * P_W'(r_b);
    r_out <= r_p;
  end

  assign o_p = r_out;
endmodule

module duty_scaler #(
  parameter int WIDTH      = 13,
  parameter int MOD_WIDTH  = 8,
  parameter int DEPTH      = 249,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic [MOD_WIDTH-1:0]  MOD,
  output logic                  BUSY,
  output logic [ADDR_WIDTH-1:0] ADDR,
  input  logic [WIDTH-1:0]      DATA_IN,
  output logic [WIDTH-1:0]      DUTY_OUT,
  output logic [ADDR_WIDTH-1:0] DUTY_IDX,
  output logic                  DUTY_VALID,
  output logic                  DONE
);
  localparam int A_W = WIDTH + 1;
  localparam int B_W = MOD_WIDTH + 2;
  localparam int P_W = A_W + B_W;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_start_acc;

  logic [ADDR_WIDTH-1:0]       r_addr;
  logic [B_W-1:0]              r_mod_b;
  logic                        r_busy;
  logic                        r_done;
  // Stage 0 = BRAM read, stages 1..3 = multiplier; the output register is the fifth stage.
  logic [3:0]                  r_vld;
  logic [3:0][ADDR_WIDTH-1:0]  r_idx;
  logic [WIDTH-1:0]            r_duty;
  logic [ADDR_WIDTH-1:0]       r_duty_idx;
  logic                        r_duty_valid;

  logic signed [A_W-1:0] w_a;
  logic signed [P_W-1:0] w_prod;
  logic signed [P_W-1:0] w_prod_adj;
  logic                  w_unused_prod;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (START) begin
          w_state_nxt = ST_RUN;
          w_start_acc = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (r_addr == LAST_ADDR) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      // Nothing enters stage 0 while draining, so an empty stage 0..3 means the pipe empties next edge.
      ST_DRAIN: begin
        if (r_vld == 4'b0000) begin
          w_state_nxt = ST_FIN;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_addr  <= {ADDR_WIDTH{1'b0}};
      r_mod_b <= {B_W{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != ST_IDLE);
      r_done <= (w_state_nxt == ST_FIN);
      if (w_start_acc) begin
        r_addr  <= {ADDR_WIDTH{1'b0}};
        r_mod_b <= {1'b0, {1'b0, MOD} + {{MOD_WIDTH{1'b0}}, 1'b1}};
      end else if ((r_state == ST_RUN) && (r_addr != LAST_ADDR)) begin
        r_addr <= r_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        r_addr <= r_addr;
      end
    end
  end

  assign w_a = {1'b0, DATA_IN};

  mult #(
    .A_W (A_W),
    .B_W (B_W)
  ) u_mult (
    .i_clk (CLK),
    .i_a   (w_a),
    .i_b   (r_mod_b),
    .o_p   (w_prod)
  );

`ifdef DUTY_SCALER_ROUND_EN
  localparam logic [P_W-1:0] RND_C = {{(P_W-1){1'b0}}, 1'b1} << (MOD_WIDTH - 1);
  assign w_prod_adj = w_prod + $signed(RND_C);
`else
  assign w_prod_adj = w_prod;
`endif

  // The product is bounded by DATA_IN*2^MOD_WIDTH, so bits above the slice are always zero.
  assign w_unused_prod = ^{w_prod_adj[P_W-1:MOD_WIDTH+WIDTH], w_prod_adj[MOD_WIDTH-1:0]};

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_vld        <= 4'b0000;
      r_idx        <= {(4*ADDR_WIDTH){1'b0}};
      r_duty       <= {WIDTH{1'b0}};
      r_duty_idx   <= {ADDR_WIDTH{1'b0}};
      r_duty_valid <= 1'b0;
    end else begin
      r_vld        <= {r_vld[2:0], (r_state == ST_RUN)};
      r_idx        <= {r_idx[2:0], r_addr};
      r_duty_valid <= r_vld[3];
      if (r_vld[3]) begin
        r_duty     <= w_prod_adj[MOD_WIDTH+WIDTH-1:MOD_WIDTH];
        r_duty_idx <= r_idx[3];
      end else begin
        r_duty     <= r_duty;
        r_duty_idx <= r_duty_idx;
      end
    end
  end

  assign BUSY       = r_busy;
  assign ADDR       = r_addr;
  assign DUTY_OUT   = r_duty;
  assign DUTY_IDX   = r_duty_idx;
  assign DUTY_VALID = r_duty_valid;
  assign DONE       = r_done;
endmodule

// File: tb/tb_duty_scaler.sv
// Scoreboard bench for duty_scaler: stimulus queues expected results, a negedge monitor checks them.
module tb_duty_scaler;
  localparam int W  = 13;
  localparam int M  = 8;
  localparam int D  = 4;
  localparam int AW = 8;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          START = 1'b0;
  logic [M-1:0]  MOD = '0;
  logic          BUSY;
  logic [AW-1:0] ADDR;
  logic [W-1:0]  DATA_IN;
  logic [W-1:0]  DUTY_OUT;
  logic [AW-1:0] DUTY_IDX;
  logic          DUTY_VALID;
  logic          DONE;

  duty_scaler #(.WIDTH(W), .MOD_WIDTH(M), .DEPTH(D), .ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .MOD(MOD), .BUSY(BUSY), .ADDR(ADDR),
    .DATA_IN(DATA_IN), .DUTY_OUT(DUTY_OUT), .DUTY_IDX(DUTY_IDX),
    .DUTY_VALID(DUTY_VALID), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [W-1:0] mem [D];
  always @(posedge CLK) DATA_IN <= mem[ADDR[1:0]];

  typedef struct { int cyc; int idx; int val; } exp_t;
  exp_t exp_q[$];
  int   done_q[$];
  int   total = 0;
  int   bad = 0;
  int   idle_from = 0;
  int   last_s = 0;
  int   nxt_exp[D];
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference: scale by (m+1)/2^M with optional round half up.
  function automatic int ref_scale(input int d, input int m);
    int p;
    p = d * (m + 1);
`ifdef DUTY_SCALER_ROUND_EN
    p = p + (1 << (M - 1));
`endif
    return p >> M;
  endfunction

  // Monitor: every cycle, either a result is due or the outputs must be quiet.
  always @(negedge CLK) begin
    exp_t e;
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        chk("duty_valid", DUTY_VALID, 1);
        if (DUTY_VALID === 1'b1) begin
          chk("duty_idx", DUTY_IDX, e.idx);
          chk("duty_out", DUTY_OUT, e.val);
        end
      end else begin
        chk("valid_idle", DUTY_VALID, 0);
      end
      if (done_q.size() > 0 && done_q[0] <= cyc) begin
        void'(done_q.pop_front());
        chk("done_pulse", DONE, 1);
      end else begin
        chk("done_idle", DONE, 0);
      end
    end
  end

  // Called at a negedge; returns one cycle later. Accepted only when the model says the block is idle.
  task automatic start_req(input int m, output bit acc);
    int s;
    START = 1'b1;
    MOD   = m[M-1:0];
    acc   = 1'b0;
    if (cyc >= idle_from) begin
      acc = 1'b1;
      s = cyc + 1;
      last_s = s;
      for (int k = 0; k < D; k++) exp_q.push_back('{s + 5 + k, k, nxt_exp[k]});
      done_q.push_back(s + D + 5);
      idle_from = s + D + 6;
    end
    @(negedge CLK);
    START = 1'b0;
    MOD   = M'($urandom);
    if (acc) begin
      chk("busy_on_start", BUSY, 1);
      chk("addr_on_start", ADDR, 0);
    end
  endtask

  task automatic finish_run();
    while (cyc < idle_from) @(negedge CLK);
    chk("busy_after_run", BUSY, 0);
    chk("addr_hold", ADDR, D - 1);
  endtask

  task automatic load(input int a, input int b, input int c, input int d);
    mem[0] = W'(a); mem[1] = W'(b); mem[2] = W'(c); mem[3] = W'(d);
  endtask

  initial begin
    bit acc;
    int rs;
    int m;
    load(0, 0, 0, 0);
    repeat (3) @(negedge CLK);
    chk("rst_busy", BUSY, 0);
    chk("rst_addr", ADDR, 0);
    chk("rst_duty_out", DUTY_OUT, 0);
    chk("rst_duty_idx", DUTY_IDX, 0);
    chk("rst_duty_valid", DUTY_VALID, 0);
    chk("rst_done", DONE, 0);
    RST_N = 1'b1;
    @(negedge CLK);
    mon_en = 1'b1;
    idle_from = cyc;

    // Identity at full-scale modulation.
    load(100, 4095, 0, 1);
    nxt_exp = '{100, 4095, 0, 1};
    start_req(255, acc);
    finish_run();

    // Modulation 127 with a START three cycles in that must be ignored.
    load(4095, 256, 255, 3);
`ifdef DUTY_SCALER_ROUND_EN
    nxt_exp = '{2048, 128, 128, 2};
`else
    nxt_exp = '{2047, 128, 127, 1};
`endif
    start_req(127, acc);
    repeat (2) @(negedge CLK);
    start_req(0, acc);
    finish_run();

    // Zero modulation gives DATA_IN >> 8.
    load(4095, 255, 0, 0);
`ifdef DUTY_SCALER_ROUND_EN
    nxt_exp = '{16, 1, 0, 0};
`else
    nxt_exp = '{15, 0, 0, 0};
`endif
    start_req(0, acc);
    finish_run();

    // START in the DONE cycle ignored, START on the next cycle accepted.
    load(100, 4095, 0, 1);
    nxt_exp = '{100, 4095, 0, 1};
    start_req(255, acc);
    while (cyc < idle_from - 1) @(negedge CLK);
    start_req(0, acc);
    chk("busy_after_fin", BUSY, 0);
    start_req(255, acc);
    finish_run();

    // Reset with two results still in flight: the aborted run yields nothing further.
    load(1000, 2000, 3000, 4000);
    for (int k = 0; k < D; k++) nxt_exp[k] = ref_scale(int'(mem[k]), 200);
    start_req(200, acc);
    rs = last_s + 6;
    while (cyc < rs) @(negedge CLK);
    RST_N = 1'b0;
    while (exp_q.size() > 0 && exp_q[$].cyc > rs) void'(exp_q.pop_back());
    while (done_q.size() > 0 && done_q[$] > rs) void'(done_q.pop_back());
    idle_from = rs + 1;
    @(negedge CLK);
    RST_N = 1'b1;
    chk("busy_after_reset", BUSY, 0);
    chk("addr_after_reset", ADDR, 0);
    repeat (8) @(negedge CLK);
    for (int k = 0; k < D; k++) nxt_exp[k] = ref_scale(int'(mem[k]), 200);
    start_req(200, acc);
    finish_run();

    // Randomized runs against the reference model.
    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < D; k++) begin
        case ($urandom_range(0, 3))
          0: mem[k] = W'(8191);
          1: mem[k] = W'($urandom_range(0, 3));
          default: mem[k] = W'($urandom_range(0, 8191));
        endcase
      end
      m = (r % 5 == 0) ? 255 : ((r % 5 == 1) ? 0 : int'($urandom_range(0, 255)));
      for (int k = 0; k < D; k++) nxt_exp[k] = ref_scale(int'(mem[k]), m);
      start_req(m, acc);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 3)) @(negedge CLK);
        start_req(int'($urandom_range(0, 255)), acc);
      end
      finish_run();
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

    repeat (10) @(negedge CLK);
    chk("results_left", exp_q.size(), 0);
    chk("dones_left", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
